freq_alarm_monitor: RTL and testbench
=====================================

FREQ_ALARM_MONITOR -- requirements
Module: freq_alarm_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the measured count and the limits.
REQ-002 SHALL have parameter FAIL_CNT, default 3: consecutive out-of-range samples needed to enter FAIL; legal range 1..255.
REQ-003 SHALL have parameter PASS_CNT, default 2: consecutive in-range samples needed to leave FAIL; legal range 1..255.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 33554432: maximum number of ref_clk cycles allowed between meas_valid pulses; legal range 1..2^32-1.
REQ-005 ref_clk  in  1  clock; all logic is in this domain.
REQ-006 resetn  in  1  reset, asynchronous, active-low.
REQ-007 meas_valid  in  1  one-cycle strobe marking a new frequency count.
REQ-008 meas_data  in  DATA_WIDTH  count sample, unsigned; sampled only when meas_valid=1.
REQ-009 lim_lo, lim_hi  in  DATA_WIDTH each  inclusive unsigned acceptance window; quasi-static.
REQ-010 clr  in  1  one-cycle strobe that clears the sticky flags and the statistics.
REQ-011 state  out  2  INIT=0, OK=1, SUSPECT=2, FAIL=3.
REQ-012 alarm  out  1  high while state=FAIL.
REQ-013 alarm_sticky  out  1  latched record of any entry into FAIL.
REQ-014 timeout_flag  out  1  latched record of a watchdog expiry.
REQ-015 last_meas  out  DATA_WIDTH  most recent accepted sample.
REQ-016 min_seen, max_seen  out  DATA_WIDTH each  sample statistics (see Configuration).

Function
REQ-017 A sample SHALL be in-range iff lim_lo <= meas_data <= lim_hi (unsigned); if lim_lo > lim_hi, every sample SHALL be out-of-range.
REQ-018 A sample arriving at edge N SHALL be reflected in state, alarm, last_meas and the statistics after edge N+1 (1-cycle latency); all outputs SHALL be registered.
REQ-019 INIT, first sample: in-range -> OK; out-of-range -> SUSPECT with viol_cnt=1, or directly FAIL if FAIL_CNT=1.
REQ-020 OK: in-range -> stay in OK; out-of-range -> as in the INIT out-of-range case.
REQ-021 SUSPECT: out-of-range -> viol_cnt+1, entering FAIL when viol_cnt reaches FAIL_CNT; in-range -> OK with viol_cnt=0.
REQ-022 FAIL: in-range -> pass_cnt+1, entering OK with pass_cnt=0 when pass_cnt reaches PASS_CNT; out-of-range -> pass_cnt=0 and stay in FAIL.
REQ-023 On entry to FAIL, viol_cnt and pass_cnt SHALL be zeroed.
REQ-024 Watchdog: a counter SHALL increment every cycle without meas_valid and reset to 0 on meas_valid.
REQ-025 When the watchdog count reaches TIMEOUT_CYCLES, the block SHALL enter FAIL from any state (including INIT), set timeout_flag, and restart the watchdog at 0.
REQ-026 If meas_valid and watchdog expiry occur in the same cycle, meas_valid SHALL win: the sample is processed and no timeout is raised.
REQ-027 alarm_sticky SHALL set on every entry into FAIL.
REQ-028 clr SHALL zero alarm_sticky and timeout_flag; if clr and a set condition coincide, the set SHALL win.
REQ-029 clr SHALL NOT affect state, alarm, last_meas or the watchdog.

Reset
REQ-030 While resetn=0: state=INIT, alarm=0, alarm_sticky=0, timeout_flag=0, last_meas=0, viol_cnt=pass_cnt=0, watchdog=0, min_seen=all-ones, max_seen=0.
REQ-031 Assertion of reset mid-operation SHALL abort any count in progress; the first sample after release SHALL be treated as an INIT sample.

Configuration
REQ-032 Macro FREQ_MON_STATS_EN SHALL control the statistics feature.
REQ-033 When FREQ_MON_STATS_EN is defined: min_seen and max_seen SHALL track the unsigned extremes of all accepted samples, whether in-range or not. clr SHALL reload min_seen to all-ones and max_seen to 0; if clr coincides with a sample, the reload SHALL be applied first and then the sample folded in.
REQ-034 When FREQ_MON_STATS_EN is undefined: min_seen and max_seen SHALL be constant 0 and no statistics registers SHALL be synthesized.

Verification
All scenarios use FAIL_CNT=3, PASS_CNT=2, TIMEOUT_CYCLES=100, lim_lo=1000, lim_hi=2000.
REQ-035 Samples 1500, 1500 -> INIT->OK after the first sample; alarm=0; last_meas=1500.
REQ-036 Samples 2500, 999, 3000 -> SUSPECT after the 1st and 2nd samples, FAIL after the 3rd; alarm=1 and alarm_sticky=1 one cycle after the 3rd strobe.
REQ-037 From FAIL, samples 1500, 2001, 1500, 2000 -> stay in FAIL until the 4th sample, then OK; alarm_sticky remains 1 until clr, then 0.
REQ-038 From OK, no meas_valid for 100 cycles -> FAIL, timeout_flag=1. Repeat with meas_valid=1500 coinciding with expiry -> state OK, timeout_flag unchanged.
REQ-039 Boundary: samples exactly 1000 and 2000 -> in-range. With lim_lo=3000, lim_hi=100 -> every sample out-of-range.
REQ-040 With FREQ_MON_STATS_EN defined: samples 1200, 800, 2600 -> min_seen=800, max_seen=2600. clr coincident with sample 1500 -> min_seen=max_seen=1500. Without the macro -> both outputs 0 throughout.

Source files
------------

// File: rtl/freq_alarm_monitor_if.sv
// Measurement strobe bundle feeding freq_alarm_monitor.
interface freq_alarm_monitor_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  meas_valid;
    logic [DATA_WIDTH-1:0] meas_data;

    modport master (output meas_valid, meas_data);
    modport slave  (input  meas_valid, meas_data);
endinterface

// File: rtl/freq_alarm_monitor.sv
// Frequency window monitor with debounce FSM, watchdog and sticky alarms.
// Define FREQ_MON_STATS_EN to build the min/max sample statistics.
module freq_alarm_monitor #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          FAIL_CNT       = 3,
    parameter int          PASS_CNT       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 33554432
) (
    input  logic                  ref_clk,
    input  logic                  resetn,
    freq_alarm_monitor_if.slave   meas,
    input  logic [DATA_WIDTH-1:0] lim_lo,
    input  logic [DATA_WIDTH-1:0] lim_hi,
    input  logic                  clr,
    output logic [1:0]            state,
    output logic                  alarm,
    output logic                  alarm_sticky,
    output logic                  timeout_flag,
    output logic [DATA_WIDTH-1:0] last_meas,
    output logic [DATA_WIDTH-1:0] min_seen,
    output logic [DATA_WIDTH-1:0] max_seen
);
    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_OK      = 2'd1;
    localparam logic [1:0] ST_SUSPECT = 2'd2;
    localparam logic [1:0] ST_FAIL    = 2'd3;

    localparam logic [7:0]  FAIL_N  = 8'(FAIL_CNT);
    localparam logic [7:0]  PASS_N  = 8'(PASS_CNT);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    // Input stage: every strobe, its range verdict and clr move together,
    // so the decision stage sees one coherent event per cycle.
    logic                  s_valid;
    logic                  s_inr;
    logic                  s_clr;
    logic [DATA_WIDTH-1:0] s_data;

    logic [7:0]  viol_cnt;
    logic [7:0]  pass_cnt;
    logic [31:0] wd_cnt;

    logic [1:0] state_nx;
    logic [7:0] viol_nx;
    logic [7:0] pass_nx;
    logic       fail_entry;
    logic       wd_expire;

    always_comb begin
        state_nx   = state;
        viol_nx    = viol_cnt;
        pass_nx    = pass_cnt;
        fail_entry = 1'b0;
        wd_expire  = !s_valid && (wd_cnt == WD_LAST);
        if (s_valid) begin
            unique case (state)
                ST_INIT, ST_OK: begin
                    if (s_inr) begin
                        state_nx = ST_OK;
                        viol_nx  = 8'd0;
                    end else if (FAIL_N == 8'd1) begin
                        fail_entry = 1'b1;
                    end else begin
                        state_nx = ST_SUSPECT;
                        viol_nx  = 8'd1;
                    end
                end
                ST_SUSPECT: begin
                    if (s_inr) begin
                        state_nx = ST_OK;
                        viol_nx  = 8'd0;
                    end else if (viol_cnt + 8'd1 >= FAIL_N) begin
                        fail_entry = 1'b1;
                    end else begin
                        viol_nx = viol_cnt + 8'd1;
                    end
                end
                ST_FAIL: begin
                    if (!s_inr) begin
                        pass_nx = 8'd0;
                    end else if (pass_cnt + 8'd1 == PASS_N) begin
                        state_nx = ST_OK;
                        pass_nx  = 8'd0;
                    end else begin
                        pass_nx = pass_cnt + 8'd1;
                    end
                end
                default: state_nx = ST_INIT;
            endcase
        end else if (wd_expire) begin
            fail_entry = 1'b1;
        end
        if (fail_entry) begin
            state_nx = ST_FAIL;
            viol_nx  = 8'd0;
            pass_nx  = 8'd0;
        end
    end

    always_ff @(posedge ref_clk or negedge resetn) begin
        if (!resetn) begin
            s_valid      <= 1'b0;
            s_inr        <= 1'b0;
            s_clr        <= 1'b0;
            s_data       <= '0;
            state        <= ST_INIT;
            alarm        <= 1'b0;
            alarm_sticky <= 1'b0;
            timeout_flag <= 1'b0;
            last_meas    <= '0;
            viol_cnt     <= 8'd0;
            pass_cnt     <= 8'd0;
            wd_cnt       <= 32'd0;
        end else begin
            s_valid <= meas.meas_valid;
            s_clr   <= clr;
            s_inr   <= (meas.meas_data >= lim_lo) && (meas.meas_data <= lim_hi);
            if (meas.meas_valid) begin
                s_data <= meas.meas_data;
            end
            state    <= state_nx;
            alarm    <= (state_nx == ST_FAIL);
            viol_cnt <= viol_nx;
            pass_cnt <= pass_nx;
            wd_cnt   <= (s_valid || wd_expire) ? 32'd0 : wd_cnt + 32'd1;
            if (s_valid) begin
                last_meas <= s_data;
            end
            // Set beats clear when both land in the same cycle.
            alarm_sticky <= fail_entry | (alarm_sticky & ~s_clr);
            timeout_flag <= wd_expire | (timeout_flag & ~s_clr);
        end
    end

`ifdef FREQ_MON_STATS_EN
    logic [DATA_WIDTH-1:0] min_q;
    logic [DATA_WIDTH-1:0] max_q;
    logic [DATA_WIDTH-1:0] min_base;
    logic [DATA_WIDTH-1:0] max_base;

    // clr reloads first so a coincident sample becomes the new extreme.
    always_comb begin
        min_base = s_clr ? '1 : min_q;
        max_base = s_clr ? '0 : max_q;
    end

    always_ff @(posedge ref_clk or negedge resetn) begin
        if (!resetn) begin
            min_q <= '1;
            max_q <= '0;
        end else if (s_valid) begin
            min_q <= (s_data < min_base) ? s_data : min_base;
            max_q <= (s_data > max_base) ? s_data : max_base;
        end else begin
            min_q <= min_base;
            max_q <= max_base;
        end
    end

    assign min_seen = min_q;
    assign max_seen = max_q;
`else
    assign min_seen = '0;
    assign max_seen = '0;
`endif
endmodule

// File: tb/tb_freq_alarm_monitor.sv
// Directed bench for freq_alarm_monitor with a per-cycle reference model.
// Builds with or without FREQ_MON_STATS_EN.
module tb_freq_alarm_monitor;
    localparam int T_OUT = 100;
    localparam int F_N   = 3;
    localparam int P_N   = 2;

    logic        ref_clk = 1'b0;
    logic        resetn  = 1'b0;
    logic        clr     = 1'b0;
    logic [31:0] lim_lo  = 32'd1000;
    logic [31:0] lim_hi  = 32'd2000;
    logic [1:0]  state;
    logic        alarm;
    logic        alarm_sticky;
    logic        timeout_flag;
    logic [31:0] last_meas;
    logic [31:0] min_seen;
    logic [31:0] max_seen;

    int checks   = 0;
    int failures = 0;

    freq_alarm_monitor_if #(.DATA_WIDTH(32)) mif ();

    freq_alarm_monitor #(
        .DATA_WIDTH(32),
        .FAIL_CNT(F_N),
        .PASS_CNT(P_N),
        .TIMEOUT_CYCLES(T_OUT)
    ) dut (
        .ref_clk(ref_clk),
        .resetn(resetn),
        .meas(mif),
        .lim_lo(lim_lo),
        .lim_hi(lim_hi),
        .clr(clr),
        .state(state),
        .alarm(alarm),
        .alarm_sticky(alarm_sticky),
        .timeout_flag(timeout_flag),
        .last_meas(last_meas),
        .min_seen(min_seen),
        .max_seen(max_seen)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: runs of good/bad samples and idle time in cycles.
    int          m_state = 0;
    int          m_bad   = 0;
    int          m_good  = 0;
    int          m_idle  = 0;
    bit          m_sticky = 0;
    bit          m_tflag  = 0;
    logic [31:0] m_last = '0;
    logic [31:0] m_min  = '1;
    logic [31:0] m_max  = '0;
    bit          p_v = 0;
    bit          p_c = 0;
    bit          p_inr = 0;
    logic [31:0] p_d = '0;
    bit          live = 0;

    task automatic model_reset();
        m_state = 0; m_bad = 0; m_good = 0; m_idle = 0;
        m_sticky = 0; m_tflag = 0; m_last = '0;
        m_min = '1; m_max = '0;
        p_v = 0; p_c = 0; p_inr = 0; p_d = '0;
    endtask

    task automatic model_apply();
        bit entered;
        bit to;
        entered = 0;
        to = 0;
        if (p_v) begin
            m_idle = 0;
            m_last = p_d;
            if (p_inr) begin
                if (m_state == 3) begin
                    m_good++;
                    if (m_good == P_N) begin
                        m_state = 1;
                        m_good = 0;
                    end
                end else begin
                    m_state = 1;
                    m_bad = 0;
                end
            end else if (m_state == 3) begin
                m_good = 0;
            end else begin
                m_bad++;
                if (m_bad >= F_N) begin
                    m_state = 3; m_bad = 0; m_good = 0; entered = 1;
                end else begin
                    m_state = 2;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == T_OUT) begin
                m_idle = 0; to = 1; entered = 1;
                m_state = 3; m_bad = 0; m_good = 0;
            end
        end
        if (p_c) begin
            m_sticky = 0; m_tflag = 0; m_min = '1; m_max = '0;
        end
        if (entered) m_sticky = 1;
        if (to) m_tflag = 1;
        if (p_v) begin
            if (p_d < m_min) m_min = p_d;
            if (p_d > m_max) m_max = p_d;
        end
    endtask

    initial begin
        forever begin
            @(posedge ref_clk);
            if (!resetn) begin
                model_reset();
            end else begin
                model_apply();
                p_v   = mif.meas_valid;
                p_d   = mif.meas_data;
                p_c   = clr;
                p_inr = (lim_lo <= mif.meas_data) && (mif.meas_data <= lim_hi);
            end
            live = 1;
        end
    end

    function automatic logic [31:0] exp_min();
`ifdef FREQ_MON_STATS_EN
        return m_min;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_max();
`ifdef FREQ_MON_STATS_EN
        return m_max;
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        forever begin
            @(negedge ref_clk);
            if (live) begin
                chk("state", 64'(state), 64'(m_state));
                chk("alarm", 64'(alarm), 64'(m_state == 3));
                chk("alarm_sticky", 64'(alarm_sticky), 64'(m_sticky));
                chk("timeout_flag", 64'(timeout_flag), 64'(m_tflag));
                chk("last_meas", 64'(last_meas), 64'(m_last));
                chk("min_seen", 64'(min_seen), 64'(exp_min()));
                chk("max_seen", 64'(max_seen), 64'(exp_max()));
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] d, input bit c);
        @(negedge ref_clk);
        #1;
        mif.meas_valid = v;
        mif.meas_data  = d;
        clr            = c;
    endtask

    task automatic send(input logic [31:0] d);
        drive(1'b1, d, 1'b0);
        drive(1'b0, 32'd0, 1'b0);
        @(negedge ref_clk);
    endtask

    task automatic do_clr();
        drive(1'b0, 32'd0, 1'b1);
        drive(1'b0, 32'd0, 1'b0);
        @(negedge ref_clk);
    endtask

    initial begin
        mif.meas_valid = 1'b0;
        mif.meas_data  = 32'd0;
        repeat (2) @(negedge ref_clk);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_alarm", 64'(alarm), 64'd0);
        chk("rst_last", 64'(last_meas), 64'd0);
`ifdef FREQ_MON_STATS_EN
        chk("rst_min", 64'(min_seen), 64'hFFFF_FFFF);
`else
        chk("rst_min", 64'(min_seen), 64'd0);
`endif
        #1 resetn = 1'b1;

        send(32'd1500);
        chk("ok_first", 64'(state), 64'd1);
        chk("ok_last", 64'(last_meas), 64'd1500);
        send(32'd1500);
        chk("ok_second", 64'(state), 64'd1);
        chk("ok_alarm", 64'(alarm), 64'd0);

        send(32'd2500);
        chk("susp_1", 64'(state), 64'd2);
        send(32'd999);
        chk("susp_2", 64'(state), 64'd2);
        send(32'd3000);
        chk("fail_3", 64'(state), 64'd3);
        chk("fail_alarm", 64'(alarm), 64'd1);
        chk("fail_sticky", 64'(alarm_sticky), 64'd1);

        send(32'd1500);
        chk("rec_1", 64'(state), 64'd3);
        send(32'd2001);
        chk("rec_2", 64'(state), 64'd3);
        send(32'd1500);
        chk("rec_3", 64'(state), 64'd3);
        send(32'd2000);
        chk("rec_4", 64'(state), 64'd1);
        chk("rec_sticky", 64'(alarm_sticky), 64'd1);
        do_clr();
        chk("clr_sticky", 64'(alarm_sticky), 64'd0);
        chk("clr_state", 64'(state), 64'd1);

        send(32'd1500);
        repeat (99) @(negedge ref_clk);
        chk("wd_before", 64'(state), 64'd1);
        chk("wd_before_flag", 64'(timeout_flag), 64'd0);
        @(negedge ref_clk);
        chk("wd_fail", 64'(state), 64'd3);
        chk("wd_flag", 64'(timeout_flag), 64'd1);

        send(32'd1500);
        send(32'd1500);
        chk("wd_recover", 64'(state), 64'd1);
        send(32'd1500);
        repeat (97) drive(1'b0, 32'd0, 1'b0);
        drive(1'b1, 32'd1500, 1'b0);
        drive(1'b0, 32'd0, 1'b0);
        @(negedge ref_clk);
        chk("wd_tie_state", 64'(state), 64'd1);
        chk("wd_tie_flag", 64'(timeout_flag), 64'd1);
        do_clr();
        chk("wd_clr_flag", 64'(timeout_flag), 64'd0);

        send(32'd1000);
        chk("edge_lo", 64'(state), 64'd1);
        send(32'd2000);
        chk("edge_hi", 64'(state), 64'd1);
        #1;
        lim_lo = 32'd3000;
        lim_hi = 32'd100;
        send(32'd2000);
        chk("inv_1", 64'(state), 64'd2);
        send(32'd50);
        chk("inv_2", 64'(state), 64'd2);
        send(32'd3500);
        chk("inv_3", 64'(state), 64'd3);
        #1;
        lim_lo = 32'd1000;
        lim_hi = 32'd2000;
        send(32'd1500);
        send(32'd1500);
        chk("inv_recover", 64'(state), 64'd1);

        send(32'd2500);
        chk("pre_rst", 64'(state), 64'd2);
        @(negedge ref_clk);
        #1 resetn = 1'b0;
        @(negedge ref_clk);
        chk("mid_rst_state", 64'(state), 64'd0);
        chk("mid_rst_sticky", 64'(alarm_sticky), 64'd0);
        #1 resetn = 1'b1;
        send(32'd2500);
        chk("post_rst_1", 64'(state), 64'd2);
        send(32'd2500);
        chk("post_rst_2", 64'(state), 64'd2);
        send(32'd2500);
        chk("post_rst_3", 64'(state), 64'd3);

        do_clr();
        send(32'd1200);
        send(32'd800);
        send(32'd2600);
`ifdef FREQ_MON_STATS_EN
        chk("stat_min", 64'(min_seen), 64'd800);
        chk("stat_max", 64'(max_seen), 64'd2600);
`else
        chk("stat_min", 64'(min_seen), 64'd0);
        chk("stat_max", 64'(max_seen), 64'd0);
`endif
        drive(1'b1, 32'd1500, 1'b1);
        drive(1'b0, 32'd0, 1'b0);
        @(negedge ref_clk);
`ifdef FREQ_MON_STATS_EN
        chk("stat_clr_min", 64'(min_seen), 64'd1500);
        chk("stat_clr_max", 64'(max_seen), 64'd1500);
`else
        chk("stat_clr_min", 64'(min_seen), 64'd0);
        chk("stat_clr_max", 64'(max_seen), 64'd0);
`endif
        chk("stat_last", 64'(last_meas), 64'd1500);

        repeat (3) @(negedge ref_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
